// File: rtl/conv_window_mac.sv
// KxK window MAC: resident kernel, LANES signed-magnitude products per cycle, shift+saturate requantise.
// Result valid K*K/LANES+1 cycles after last x row; result held until y_ready, no loads accepted meanwhile.
module conv_window_mac #(
  parameter int N     = 16,
  parameter int K     = 3,
  parameter int LANES = 1,
  parameter int FRAC  = 0,
  parameter int ACCW  = 2*(N-1)+$clog2(K*K)+1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           w_valid,
  output logic           w_ready,
  input  logic [K*N-1:0] w_row,
  input  logic           x_valid,
  output logic           x_ready,
  input  logic [K*N-1:0] x_row,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [N-1:0]   y_data,
  output logic           y_sat,
  output logic           busy
);

  localparam int EL   = K*K;
  localparam int MACC = EL/LANES;
  localparam int RW   = (K > 1) ? $clog2(K) : 1;
  localparam int EW   = (EL > 1) ? $clog2(EL) : 1;
  localparam int CW   = $clog2(MACC+1);
  localparam int MW   = 2*N-2;
  localparam logic [ACCW-1:0] MAXMAG = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WLOAD = 3'd1;
  localparam logic [2:0] S_XLOAD = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            wt_ok_q, wt_ok_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [N-1:0]    y_data_q, y_data_d;
  logic            y_sat_q, y_sat_d;
  logic [N-1:0]    w_mem_q [EL];
  logic [N-1:0]    w_mem_d [EL];
  logic [N-1:0]    x_mem_q [EL];
  logic [N-1:0]    x_mem_d [EL];

  logic            w_wr, x_wr;
  logic [MW-1:0]   prod [LANES];
  logic            sgn  [LANES];
  logic [ACCW-1:0] lane_sum;
  logic [ACCW-1:0] shr, mag_r;
  logic            neg, sat;

  // Lane l of MAC cycle c handles element c*LANES+l in row-major order.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = '0;
      sgn[l]  = 1'b0;
      if (int'(cnt_q)*LANES + l < EL) begin
        prod[l] = MW'(x_mem_q[EW'(int'(cnt_q)*LANES + l)][N-2:0]) *
                  MW'(w_mem_q[EW'(int'(cnt_q)*LANES + l)][N-2:0]);
        sgn[l]  = x_mem_q[EW'(int'(cnt_q)*LANES + l)][N-1] ^
                  w_mem_q[EW'(int'(cnt_q)*LANES + l)][N-1];
      end
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + (sgn[l] ? -ACCW'(prod[l]) : ACCW'(prod[l]));
    end
  end

  // Arithmetic shift floors toward -inf; magnitude then saturates to N-1 bits.
  always_comb begin
    shr   = $signed(acc_q) >>> FRAC;
    neg   = shr[ACCW-1];
    mag_r = neg ? -shr : shr;
    sat   = mag_r > MAXMAG;
  end

  always_comb begin
    state_d  = state_q;
    wt_ok_d  = wt_ok_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    y_data_d = y_data_q;
    y_sat_d  = y_sat_q;
    w_ready  = 1'b0;
    x_ready  = 1'b0;
    w_wr     = 1'b0;
    x_wr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        w_ready = 1'b1;
        x_ready = wt_ok_q;
        if (w_valid) begin
          w_wr = 1'b1;
          if (K == 1) begin
            wt_ok_d = 1'b1;
          end else begin
            wt_ok_d = 1'b0;
            row_d   = RW'(1);
            state_d = S_WLOAD;
          end
        end else if (x_valid && wt_ok_q) begin
          x_wr = 1'b1;
          if (K == 1) begin
            cnt_d   = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end else begin
            row_d   = RW'(1);
            state_d = S_XLOAD;
          end
        end
      end
      S_WLOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_wr = 1'b1;
          if (row_q == RW'(K-1)) begin
            row_d   = '0;
            wt_ok_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_XLOAD: begin
        x_ready = 1'b1;
        if (x_valid) begin
          x_wr = 1'b1;
          if (row_q == RW'(K-1)) begin
            row_d   = '0;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        if (cnt_q < CW'(MACC)) begin
          acc_d = acc_q + lane_sum;
          cnt_d = cnt_q + 1'b1;
        end else begin
          y_sat_d  = sat;
          y_data_d = {neg, sat ? {(N-1){1'b1}} : mag_r[N-2:0]};
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (y_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_d = w_mem_q;
    x_mem_d = x_mem_q;
    for (int c = 0; c < K; c++) begin
      if (w_wr) w_mem_d[EW'(int'(row_q)*K + c)] = w_row[N*c +: N];
      if (x_wr) x_mem_d[EW'(int'(row_q)*K + c)] = x_row[N*c +: N];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wt_ok_q  <= 1'b0;
      row_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      y_data_q <= '0;
      y_sat_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wt_ok_q  <= wt_ok_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      y_data_q <= y_data_d;
      y_sat_q  <= y_sat_d;
    end
  end

  // Storage contents are qualified by wt_ok/state, so no reset is needed here.
  always_ff @(posedge clk) begin
    w_mem_q <= w_mem_d;
    x_mem_q <= x_mem_d;
  end

  assign y_valid = (state_q == S_OUT);
  assign busy    = (state_q != S_IDLE);
  assign y_data  = y_data_q;
  assign y_sat   = y_sat_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench: dut0 is N=16,K=3,LANES=1,FRAC=0; dut1 is LANES=3,FRAC=2.
module tb_conv_window_mac;
  localparam int N = 16;
  localparam int K = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n [2];
  logic           w_valid [2];
  logic           w_ready [2];
  logic [K*N-1:0] w_row [2];
  logic           x_valid [2];
  logic           x_ready [2];
  logic [K*N-1:0] x_row [2];
  logic           y_valid [2];
  logic           y_ready [2];
  logic [N-1:0]   y_data [2];
  logic           y_sat [2];
  logic           busy [2];

  conv_window_mac #(.N(N), .K(K), .LANES(1), .FRAC(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .w_valid(w_valid[0]), .w_ready(w_ready[0]), .w_row(w_row[0]),
    .x_valid(x_valid[0]), .x_ready(x_ready[0]), .x_row(x_row[0]),
    .y_valid(y_valid[0]), .y_ready(y_ready[0]), .y_data(y_data[0]),
    .y_sat(y_sat[0]), .busy(busy[0])
  );

  conv_window_mac #(.N(N), .K(K), .LANES(3), .FRAC(2)) dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .w_valid(w_valid[1]), .w_ready(w_ready[1]), .w_row(w_row[1]),
    .x_valid(x_valid[1]), .x_ready(x_ready[1]), .x_row(x_row[1]),
    .y_valid(y_valid[1]), .y_ready(y_ready[1]), .y_data(y_data[1]),
    .y_sat(y_sat[1]), .busy(busy[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [N:0] exp_q0 [$];
  logic [N:0] exp_q1 [$];
  logic [N:0] e0, e1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_bound(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic logic [K*N-1:0] r3(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic [N-1:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [K*N-1:0] fill(input logic [N-1:0] v);
    return {v, v, v};
  endfunction

  // Monitors: every y handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n[0] && y_valid[0] && y_ready[0]) begin
      if (exp_q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL y0_unexpected: got %h with no result expected", {y_sat[0], y_data[0]});
      end else begin
        e0 = exp_q0.pop_front();
        chk("y0", {15'd0, y_sat[0], y_data[0]}, {15'd0, e0});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n[1] && y_valid[1] && y_ready[1]) begin
      if (exp_q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL y1_unexpected: got %h with no result expected", {y_sat[1], y_data[1]});
      end else begin
        e1 = exp_q1.pop_front();
        chk("y1", {15'd0, y_sat[1], y_data[1]}, {15'd0, e1});
      end
    end
  end

  task automatic send(input int d, input bit is_x, input logic [K*N-1:0] row);
    int t;
    t = 0;
    if (is_x) begin x_valid[d] = 1'b1; x_row[d] = row; end
    else      begin w_valid[d] = 1'b1; w_row[d] = row; end
    @(negedge clk);
    while (!(is_x ? x_ready[d] : w_ready[d]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_bound(is_x ? "x_beat" : "w_beat");
    @(posedge clk);
    #1;
    if (is_x) x_valid[d] = 1'b0;
    else      w_valid[d] = 1'b0;
  endtask

  task automatic load_kernel(input int d, input logic [K*N-1:0] a, input logic [K*N-1:0] b,
                             input logic [K*N-1:0] c);
    send(d, 1'b0, a);
    send(d, 1'b0, b);
    send(d, 1'b0, c);
  endtask

  task automatic window(input int d, input logic [K*N-1:0] a, input logic [K*N-1:0] b,
                        input logic [K*N-1:0] c, input logic [N:0] exp);
    if (d == 0) exp_q0.push_back(exp);
    else        exp_q1.push_back(exp);
    send(d, 1'b1, a);
    send(d, 1'b1, b);
    send(d, 1'b1, c);
  endtask

  task automatic wait_y(input int d, input int exp_edges);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!y_valid[d] && n < 40);
    chk(d == 0 ? "latency0" : "latency1", n, exp_edges);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int seen;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; w_valid[d] = 1'b0; x_valid[d] = 1'b0; y_ready[d] = 1'b1;
      w_row[d] = '0; x_row[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_y_valid", {31'd0, y_valid[d]}, 32'd0);
      chk("rst_y_data", {16'd0, y_data[d]}, 32'd0);
      chk("rst_busy", {31'd0, busy[d]}, 32'd0);
      chk("rst_w_ready", {31'd0, w_ready[d]}, 32'd1);
      chk("rst_x_ready", {31'd0, x_ready[d]}, 32'd0);
    end

    // Window beats offered before any kernel must be refused.
    x_valid[0] = 1'b1;
    x_row[0] = fill(16'h0002);
    repeat (3) begin
      @(negedge clk);
      chk("nokernel_x_ready", {31'd0, x_ready[0]}, 32'd0);
      chk("nokernel_busy", {31'd0, busy[0]}, 32'd0);
    end
    @(posedge clk);
    #1;
    x_valid[0] = 1'b0;

    load_kernel(0, fill(16'h0001), fill(16'h0001), fill(16'h0001));
    window(0, fill(16'h0002), fill(16'h0002), fill(16'h0002), {1'b0, 16'h0012});
    wait_y(0, 10);

    // 5*12 - 4*12 = 12; 9*(-12) = -108; negative zeros contribute nothing.
    load_kernel(0, fill(16'h0003), fill(16'h0003), fill(16'h0003));
    window(0, fill(16'h0004), r3(16'h0004, 16'h0004, 16'h8004), fill(16'h8004), {1'b0, 16'h000C});
    window(0, fill(16'h8004), fill(16'h8004), fill(16'h8004), {1'b0, 16'h806C});
    window(0, fill(16'h8000), fill(16'h8000), fill(16'h8000), {1'b0, 16'h0000});

    load_kernel(0, fill(16'h7FFF), fill(16'h7FFF), fill(16'h7FFF));
    window(0, fill(16'h7FFF), fill(16'h7FFF), fill(16'h7FFF), {1'b1, 16'h7FFF});
    window(0, fill(16'hFFFF), fill(16'hFFFF), fill(16'hFFFF), {1'b1, 16'hFFFF});

    // Output stall: 9*2*5 = 90 held for 5 cycles, then kernel reused for 9*(-2) = -18.
    load_kernel(0, fill(16'h0002), fill(16'h0002), fill(16'h0002));
    y_ready[0] = 1'b0;
    window(0, fill(16'h0005), fill(16'h0005), fill(16'h0005), {1'b0, 16'h005A});
    wait_y(0, 10);
    repeat (5) begin
      @(negedge clk);
      chk("stall_y_valid", {31'd0, y_valid[0]}, 32'd1);
      chk("stall_y_data", {15'd0, y_sat[0], y_data[0]}, {15'd0, 1'b0, 16'h005A});
      chk("stall_x_ready", {31'd0, x_ready[0]}, 32'd0);
    end
    @(posedge clk);
    #1;
    y_ready[0] = 1'b1;
    window(0, fill(16'h8001), fill(16'h8001), fill(16'h8001), {1'b0, 16'h8012});

    // dut1: 18>>>2 = 4; -5>>>2 = -2; -1>>>2 = -1; 7>>>2 = 1.
    load_kernel(1, fill(16'h0001), fill(16'h0001), fill(16'h0001));
    window(1, fill(16'h0002), fill(16'h0002), fill(16'h0002), {1'b0, 16'h0004});
    wait_y(1, 4);
    load_kernel(1, r3(16'h0001, 16'h0000, 16'h0000), fill(16'h0000), fill(16'h0000));
    window(1, r3(16'h8005, 16'h0007, 16'h0007), fill(16'h0007), fill(16'h0007), {1'b0, 16'h8002});
    window(1, r3(16'h8001, 16'h0007, 16'h0007), fill(16'h0007), fill(16'h0007), {1'b0, 16'h8001});
    window(1, r3(16'h0007, 16'h0007, 16'h0007), fill(16'h0007), fill(16'h0007), {1'b0, 16'h0001});

    // Reset in the middle of accumulation on dut0 must discard the window.
    t = 0;
    while (exp_q0.size() != 0 && t < 200) begin @(negedge clk); t++; end
    load_kernel(0, fill(16'h0001), fill(16'h0001), fill(16'h0001));
    send(0, 1'b1, fill(16'h0003));
    send(0, 1'b1, fill(16'h0003));
    send(0, 1'b1, fill(16'h0003));
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (y_valid[0]) seen++;
    end
    chk("abort_y_valid_count", seen, 0);
    chk("abort_x_ready", {31'd0, x_ready[0]}, 32'd0);
    chk("abort_busy", {31'd0, busy[0]}, 32'd0);

    t = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
